alu_issue_unit: RTL and testbench
=================================

// Module: alu_issue_unit
// PURPOSE
//  Upstream issue/retire stage for the combinational alu (WIDTH=8).
//  Buffers operand/opcode commands in a DEPTH-entry FIFO (valid/ready in).
//  Drives one command at a time onto the alu inputs, registers alu y one cycle later.
//  Returns the registered result through a valid/ready output handshake; traps divide-by-zero.
// PARAMETERS
//  WIDTH  8  alu result width; operands WIDTH/2, opcode $clog2(WIDTH) bits
//  DEPTH  4  command FIFO entries, power of two >= 2
// PORTS
//  clk        in   1              single clock, rising edge
//  rst_n      in   1              asynchronous, active-low reset
//  cmd_valid  in   1              command present
//  cmd_ready  out  1              FIFO can accept (= !full)
//  cmd_a      in   WIDTH/2        operand a
//  cmd_b      in   WIDTH/2        operand b
//  cmd_op     in   $clog2(WIDTH)  opcode 0..7
//  alu_a      out  WIDTH/2        to alu a (registered)
//  alu_b      out  WIDTH/2        to alu b (registered)
//  alu_op     out  $clog2(WIDTH)  to alu opcode (registered)
//  alu_y      in   WIDTH          from alu y
//  res_valid  out  1              result held
//  res_ready  in   1              consumer takes result
//  res_y      out  WIDTH          registered result
//  res_op     out  $clog2(WIDTH)  opcode that produced res_y
//  res_err    out  1              divide-by-zero flag for this result
//  count      out  $clog2(DEPTH)+1  FIFO occupancy
//  busy       out  1              FSM not IDLE or count != 0
// BEHAVIOUR
//  Reset (async, rst_n=0): FSM=IDLE, FIFO empty, count=0, cmd_ready=1, res_valid=0,
//   res_y=0, res_op=0, res_err=0, alu_a/alu_b/alu_op=0, busy=0. Pending commands discarded.
//  Push: cmd_valid&&cmd_ready at edge writes {a,b,op}. Full -> cmd_ready=0 and push refused,
//   even if a pop occurs the same cycle. Push and pop in one cycle: count unchanged.
//  FSM states IDLE, EXEC, HOLD:
//   IDLE: count!=0 -> pop head into alu_a/b/op, go EXEC; else stay.
//   EXEC: one cycle, alu inputs stable. At edge: res_y<=alu_y, res_op<=alu_op,
//    res_valid<=1, go HOLD. If alu_op==3 && alu_b==0: res_y<={WIDTH{1'b1}}, res_err<=1.
//   HOLD: res_* stable while res_valid && !res_ready. On res_ready: res_valid<=0;
//    count!=0 -> pop next into alu regs, go EXEC (same edge); else go IDLE.
//  Latency: command pushed into empty idle unit at edge T0 -> popped T1 -> res_valid high
//   after T2. Back-to-back throughput with res_ready=1: one result per 2 cycles.
//  alu_* change only on a pop; they hold the last command in IDLE/HOLD.
//  Results emerge strictly in command order; none dropped or duplicated.
//  FIFO pointers wrap modulo DEPTH; count is the full/empty authority (full: count==DEPTH).
//  res_err clears on the pop that loads the next command; res_valid never high in IDLE/EXEC.
// TESTING (bench instantiates a real alu, WIDTH=8)
//  Add: a=3,b=5,op=0, res_ready=1 -> res_valid after 2 edges, res_y=8'h08, res_err=0.
//  Mul/concat: a=F,b=F,op=2 then a=A,b=5,op=7 -> res_y=8'hE1 then 8'hA5, in order.
//  Div-by-zero: a=9,b=0,op=3 -> res_y=8'hFF, res_err=1; next op=5 a=C,b=A -> 8'h08, res_err=0.
//  Backpressure: res_ready=0, push 6 cmds -> 1 in HOLD, 1 issued... FIFO fills to count=4,
//   cmd_ready=0, 6th refused; release res_ready -> all accepted results out in order.
//  Simultaneous: count=2, push and HOLD-retire same edge -> count stays 2, order kept.
//  Reset mid-op: assert rst_n=0 during HOLD with count=3 -> all outputs to reset values
//   immediately (async); after release new cmd a=1,b=1,op=0 -> res_y=8'h02.

Source files
------------

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: issue/retire stage wrapped around a combinational alu.
// Commands {a, b, op} are queued in a small FIFO, issued one at a time onto
// registered alu inputs, and the alu result is captured one cycle later and
// offered downstream through a valid/ready handshake. An opcode-3 command
// with a zero b operand is trapped as a divide-by-zero: the result is
// forced to all ones and res_err is raised.
module alu_issue_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    // command side
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [WIDTH/2-1:0]         cmd_a,
    input  logic [WIDTH/2-1:0]         cmd_b,
    input  logic [$clog2(WIDTH)-1:0]   cmd_op,
    // alu side
    output logic [WIDTH/2-1:0]         alu_a,
    output logic [WIDTH/2-1:0]         alu_b,
    output logic [$clog2(WIDTH)-1:0]   alu_op,
    input  logic [WIDTH-1:0]           alu_y,
    // result side
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [WIDTH-1:0]           res_y,
    output logic [$clog2(WIDTH)-1:0]   res_op,
    output logic                       res_err,
    // status
    output logic [$clog2(DEPTH):0]     count,
    output logic                       busy
);

    localparam int OPW = $clog2(WIDTH);
    localparam int OW  = WIDTH / 2;
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;

    localparam logic [OPW-1:0] OP_DIV = OPW'(3);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [OW-1:0]  r_mem_a  [DEPTH];
    logic [OW-1:0]  r_mem_b  [DEPTH];
    logic [OPW-1:0] r_mem_op [DEPTH];

    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;

    // ------------------------------------------------------------------
    // Issue FSM state and registered outputs
    // ------------------------------------------------------------------
    state_t         r_state;
    logic [OW-1:0]  r_alu_a;
    logic [OW-1:0]  r_alu_b;
    logic [OPW-1:0] r_alu_op;
    logic           r_res_valid;
    logic [WIDTH-1:0] r_res_y;
    logic [OPW-1:0] r_res_op;
    logic           r_res_err;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;
    logic           w_div_zero;
    logic [OW-1:0]  w_head_a;
    logic [OW-1:0]  w_head_b;
    logic [OPW-1:0] w_head_op;

    // count is the only full/empty authority; pointers merely wrap
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // a full FIFO refuses a push even if the same edge pops an entry
    assign w_push  = cmd_valid && !w_full;

    // the head is consumed whenever the FSM is free to issue: from IDLE, or
    // from HOLD on the edge the current result is taken
    assign w_pop   = !w_empty &&
                     ((r_state == S_IDLE) || ((r_state == S_HOLD) && res_ready));

    assign w_head_a  = r_mem_a[r_rd_ptr];
    assign w_head_b  = r_mem_b[r_rd_ptr];
    assign w_head_op = r_mem_op[r_rd_ptr];

    // trap is decided from the registered alu inputs that produced alu_y
    assign w_div_zero = (r_alu_op == OP_DIV) && (r_alu_b == '0);

    // FIFO payload write; storage needs no reset since count gates reads
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr]  <= cmd_a;
            r_mem_b[r_wr_ptr]  <= cmd_b;
            r_mem_op[r_wr_ptr] <= cmd_op;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Issue FSM: pop into the alu registers, capture the result, hold it
    // until the consumer takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_res_valid <= 1'b0;
            r_res_y     <= '0;
            r_res_op    <= '0;
            r_res_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_alu_a   <= w_head_a;
                        r_alu_b   <= w_head_b;
                        r_alu_op  <= w_head_op;
                        r_res_err <= 1'b0;
                        r_state   <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    // alu inputs have been stable for a full cycle here
                    r_res_valid <= 1'b1;
                    r_res_op    <= r_alu_op;
                    if (w_div_zero) begin
                        r_res_y   <= {WIDTH{1'b1}};
                        r_res_err <= 1'b1;
                    end else begin
                        r_res_y   <= alu_y;
                        r_res_err <= 1'b0;
                    end
                    r_state <= S_HOLD;
                end

                S_HOLD: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        if (w_pop) begin
                            // retire and issue on the same edge
                            r_alu_a   <= w_head_a;
                            r_alu_b   <= w_head_b;
                            r_alu_op  <= w_head_op;
                            r_res_err <= 1'b0;
                            r_state   <= S_EXEC;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign cmd_ready = !w_full;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign res_valid = r_res_valid;
    assign res_y     = r_res_y;
    assign res_op    = r_res_op;
    assign res_err   = r_res_err;
    assign count     = r_count;
    assign busy      = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit: directed bench for alu_issue_unit with a behavioural
// 8-bit alu attached to the alu_* ports.
module tb_alu_issue_unit;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_y;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_y;
    logic [2:0] res_op;
    logic       res_err;
    logic [2:0] count;
    logic       busy;

    int total = 0;
    int bad   = 0;

    alu_issue_unit #(.WIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_op    (cmd_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_y     (alu_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_y     (res_y),
        .res_op    (res_op),
        .res_err   (res_err),
        .count     (count),
        .busy      (busy)
    );

    // behavioural alu: add, sub, mul, div, mod, and, or, concat
    always_comb begin
        alu_y = 8'h00;
        case (alu_op)
            3'd0: alu_y = {4'h0, alu_a} + {4'h0, alu_b};
            3'd1: alu_y = {4'h0, alu_a} - {4'h0, alu_b};
            3'd2: alu_y = {4'h0, alu_a} * {4'h0, alu_b};
            3'd3: alu_y = (alu_b == 4'h0) ? 8'h00 : ({4'h0, alu_a} / {4'h0, alu_b});
            3'd4: alu_y = (alu_b == 4'h0) ? 8'h00 : ({4'h0, alu_a} % {4'h0, alu_b});
            3'd5: alu_y = {4'h0, alu_a & alu_b};
            3'd6: alu_y = {4'h0, alu_a | alu_b};
            default: alu_y = {alu_a, alu_b};
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cnt"},  32'(count),     32'd0);
        chk({tag, "_crdy"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_rvld"}, 32'(res_valid), 32'd0);
        chk({tag, "_ry"},   32'(res_y),     32'd0);
        chk({tag, "_rop"},  32'(res_op),    32'd0);
        chk({tag, "_rerr"}, 32'(res_err),   32'd0);
        chk({tag, "_aa"},   32'(alu_a),     32'd0);
        chk({tag, "_ab"},   32'(alu_b),     32'd0);
        chk({tag, "_aop"},  32'(alu_op),    32'd0);
        chk({tag, "_busy"}, 32'(busy),      32'd0);
    endtask

    // wait (bounded) for a result, check it, and let res_ready take it
    task automatic take(input string tag, input logic [7:0] y, input logic err, input logic [2:0] op);
        int n = 0;
        while (!res_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_vld"}, 32'(res_valid), 32'd1);
        chk({tag, "_y"},   32'(res_y),     32'(y));
        chk({tag, "_err"}, 32'(res_err),   32'(err));
        chk({tag, "_op"},  32'(res_op),    32'(op));
        $display("result %s: y=%02h err=%0d op=%0d (want %02h/%0d/%0d)",
                 tag, res_y, res_err, res_op, y, err, op);
        step();
    endtask

    logic [3:0] bp_a  [6] = '{4'h1, 4'h4, 4'h7, 4'hB, 4'hE, 4'h5};
    logic [3:0] bp_b  [6] = '{4'h2, 4'h3, 4'h0, 4'h6, 4'h3, 4'h5};
    logic [2:0] bp_op [6] = '{3'd0, 3'd2, 3'd3, 3'd7, 3'd5, 3'd0};
    logic [7:0] bp_y  [6] = '{8'h03, 8'h0C, 8'hFF, 8'hB6, 8'h02, 8'h0A};

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_a     = 4'h0;
        cmd_b     = 4'h0;
        cmd_op    = 3'd0;
        res_ready = 1'b0;
        step();
        step();
        chk_reset("rst");
        rst_n = 1'b1;
        step();

        // add with latency checks
        res_ready = 1'b1;
        push(4'h3, 4'h5, 3'd0);
        chk("add_t0_cnt",  32'(count),     32'd1);
        chk("add_t0_vld",  32'(res_valid), 32'd0);
        chk("add_t0_busy", 32'(busy),      32'd1);
        step();
        chk("add_t1_aa",   32'(alu_a),     32'd3);
        chk("add_t1_ab",   32'(alu_b),     32'd5);
        chk("add_t1_cnt",  32'(count),     32'd0);
        chk("add_t1_vld",  32'(res_valid), 32'd0);
        step();
        chk("add_t2_vld",  32'(res_valid), 32'd1);
        chk("add_t2_y",    32'(res_y),     32'h08);
        chk("add_t2_err",  32'(res_err),   32'd0);
        $display("result add: y=%02h err=%0d", res_y, res_err);
        step();
        chk("add_ret_vld",  32'(res_valid), 32'd0);
        chk("add_ret_busy", 32'(busy),      32'd0);

        // mul then concat, back to back
        push(4'hF, 4'hF, 3'd2);
        push(4'hA, 4'h5, 3'd7);
        take("mul", 8'hE1, 1'b0, 3'd2);
        take("cat", 8'hA5, 1'b0, 3'd7);

        // divide by zero trap, then a clean command
        push(4'h9, 4'h0, 3'd3);
        take("div0", 8'hFF, 1'b1, 3'd3);
        chk("idle_hold_aa", 32'(alu_a), 32'd9);
        chk("idle_hold_ab", 32'(alu_b), 32'd0);
        push(4'hC, 4'hA, 3'd5);
        take("and", 8'h08, 1'b0, 3'd5);

        // backpressure: fill the FIFO, sixth command refused
        res_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cmd_a     = bp_a[k];
            cmd_b     = bp_b[k];
            cmd_op    = bp_op[k];
            cmd_valid = 1'b1;
            chk("bp_rdy", 32'(cmd_ready), (k < 5) ? 32'd1 : 32'd0);
            step();
        end
        cmd_valid = 1'b0;
        chk("bp_cnt",  32'(count),     32'd4);
        chk("bp_crdy", 32'(cmd_ready), 32'd0);
        chk("bp_vld",  32'(res_valid), 32'd1);
        step();
        step();
        chk("bp_hold_y",  32'(res_y),     32'h03);
        chk("bp_hold_v",  32'(res_valid), 32'd1);
        chk("bp_hold_aa", 32'(alu_a),     32'd1);
        chk("bp_hold_c",  32'(count),     32'd4);
        res_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            take($sformatf("bp%0d", k), bp_y[k], (k == 2), bp_op[k]);
        end
        step();
        step();
        chk("bp_end_vld",  32'(res_valid), 32'd0);
        chk("bp_end_busy", 32'(busy),      32'd0);
        chk("bp_end_cnt",  32'(count),     32'd0);

        // simultaneous push and retire with count=2
        res_ready = 1'b0;
        push(4'h1, 4'h1, 3'd0);
        push(4'h2, 4'h2, 3'd0);
        push(4'h3, 4'h3, 3'd0);
        chk("sim_cnt0", 32'(count),     32'd2);
        chk("sim_vld0", 32'(res_valid), 32'd1);
        chk("sim_y0",   32'(res_y),     32'h02);
        cmd_a     = 4'h4;
        cmd_b     = 4'h4;
        cmd_op    = 3'd0;
        cmd_valid = 1'b1;
        res_ready = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("sim_cnt1", 32'(count),     32'd2);
        chk("sim_vld1", 32'(res_valid), 32'd0);
        chk("sim_aa1",  32'(alu_a),     32'd2);
        take("sim1", 8'h04, 1'b0, 3'd0);
        take("sim2", 8'h06, 1'b0, 3'd0);
        take("sim3", 8'h08, 1'b0, 3'd0);

        // asynchronous reset during HOLD with count=3
        res_ready = 1'b0;
        push(4'h5, 4'h1, 3'd0);
        push(4'h6, 4'h1, 3'd0);
        push(4'h7, 4'h1, 3'd0);
        push(4'h8, 4'h1, 3'd0);
        chk("ar_cnt", 32'(count),     32'd3);
        chk("ar_vld", 32'(res_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("arst");
        step();
        step();
        #1;
        rst_n = 1'b1;
        res_ready = 1'b1;
        push(4'h1, 4'h1, 3'd0);
        take("post", 8'h02, 1'b0, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
